apb_reg_completer: RTL
======================

# apb_reg_completer

APB3 completer holding a small 32-bit register file. It sits directly downstream of the team's APB bridge and answers the bridge's setup/access transfers with a fixed, parameterised number of wait states. It returns read data, commits writes and flags errors on `pslverr`, so the bridge's read/write/error paths can be exercised against real sequential behaviour.

## Interface
- `ADDR_WIDTH`, 32, width of `paddr`
- `DATA_WIDTH`, 32, width of `pwdata`/`prdata`
- `NUM_REGS`, 8, number of 32-bit word registers (≥4); valid byte addresses are 0 to NUM_REGS*4-4
- `WAIT_STATES`, 2, access-phase cycles with `pready`=0 before the completing cycle (0 allowed)
- `ID_VALUE`, 32'hA5B0_0001, constant returned by the ID register
- `pclk` input 1: single clock; all logic on the rising edge
- `preset` input 1: reset, synchronous, active-high
- `psel` input 1: completer select
- `penable` input 1: access-phase indicator
- `pwrite` input 1: 1 = write, 0 = read
- `paddr` input ADDR_WIDTH: byte address
- `pwdata` input DATA_WIDTH: write data
- `prdata` output DATA_WIDTH: read data, valid only while `pready`=1
- `pready` output 1: transfer completes this cycle
- `pslverr` output 1: error response, valid only while `pready`=1

## Operation
- Register map, by word index `paddr[ADDR_WIDTH-1:2]`:
  - 0x00 ID: read-only, reads `ID_VALUE`
  - 0x04 CTRL: read/write, reset 0
  - 0x08 XFER_CNT: read-only, counts transfers completed without error, wraps at 2^32
  - 0x0C ERR_CNT: read-only, counts transfers completed with `pslverr`=1, saturates at 32'hFFFF_FFFF
  - 0x10 up to (NUM_REGS-1)*4: general read/write registers, reset 0
- Error conditions, decoded once at setup:
  - `paddr[1:0]`≠0
  - address ≥ NUM_REGS*4
  - write to ID, XFER_CNT or ERR_CNT
- Error response: `pslverr`=1 and `prdata`=0. No register changes except ERR_CNT.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on an edge sampling `psel`=1 and `penable`=0 (setup), latch `paddr`, `pwrite` and the error decode. Go to WAIT with `cnt`=WAIT_STATES, or straight to RESP if WAIT_STATES=0.
  - WAIT: `cnt` decrements each edge. When `cnt`=1, go to RESP. If `psel`=0 is sampled, abort to IDLE with no write and no counter update.
  - RESP: `pready`=1; `prdata`/`pslverr` driven from registered values. At the closing edge, commit the write (using `pwdata` sampled at that edge), update XFER_CNT or ERR_CNT, and go to IDLE.
- A read of XFER_CNT or ERR_CNT returns the value before the current transfer is counted.
- `penable`=1 while in IDLE without a preceding setup is ignored.
- A setup cycle directly after RESP is accepted normally (back-to-back transfers).

## Timing
- Reset: on any edge with `preset`=1, at the next edge state=IDLE; `pready`, `pslverr`, `prdata`=0; CTRL, general registers, XFER_CNT and ERR_CNT=0. This applies in every state, including mid-transfer. No write is committed.
- Setup cycle T0 is followed by access cycles T1… `pready`=1 in exactly cycle T1+WAIT_STATES, for one cycle only.
- Total latency from setup to completion = WAIT_STATES+2 cycles. Minimum between transfer starts = WAIT_STATES+2 cycles.
- `prdata`/`pslverr` are 0 whenever `pready`=0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- After reset, with WAIT_STATES=2, read 0x00 → `pready` high in the third access cycle, `prdata`=32'hA5B0_0001, `pslverr`=0. Repeat with WAIT_STATES=0 → `pready` in the first access cycle.
- Write 0x04=32'h1234_5678, then read 0x04 → 32'h1234_5678. Then read 0x08 → 2.
- Write 0x00=32'hFFFF_FFFF → `pslverr`=1. Read 0x00 → ID_VALUE unchanged. Read 0x0C → 1.
- Read 0x20 (NUM_REGS=8) and read 0x06 → each gives `pslverr`=1, `prdata`=0. ERR_CNT increases by 2; XFER_CNT unchanged.
- Write 0x10 with `psel` dropped during WAIT → `pready` never asserts. Read 0x10 → 0. A following read of 0x04 completes normally.
- Assert `preset` for one cycle during WAIT of a write to 0x04 → all outputs 0 at the next edge. Read 0x04 → 0; XFER_CNT=0.

Source files
------------

// File: rtl/apb_reg_completer_if.sv
// APB3 bus bundle between a requester (bridge) and the register completer.
//   master modport : drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave modport  : the mirror image, used by apb_reg_completer
interface apb_reg_completer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_reg_completer.sv
// APB3 completer with a small word register file and a fixed number of wait states.
//   pclk   : clock, rising edge
//   preset : synchronous active-high reset
//   apb    : slave side of the APB bus (psel, penable, pwrite, paddr, pwdata in;
//            prdata, pready, pslverr out, all registered)
// Map (word index): 0 ID (RO), 1 CTRL (RW), 2 XFER_CNT (RO), 3 ERR_CNT (RO),
// 4..NUM_REGS-1 general RW. Errors are decoded once, at the setup cycle.
module apb_reg_completer #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input logic                pclk,
   input logic                preset,
   apb_reg_completer_if.slave apb
);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Transfer attributes captured at setup and held through the access phase.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             wr;
      logic             err;
   } req_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   req_t                  req_q, req_in, req_sel;
   logic                  setup;
   logic [DATA_WIDTH-1:0] regs [2**IDX_W];
   logic [DATA_WIDTH-1:0] xfer_cnt, err_cnt;
   logic [DATA_WIDTH-1:0] rd_mux, rd_val;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  pready_q, pslverr_q;

   assign setup = (state == IDLE) && apb.psel && !apb.penable;

   // Live decode of the bus, used at the setup edge.
   always_comb begin
      req_in     = '0;
      req_in.idx = apb.paddr[IDX_W+1:2];
      req_in.wr  = apb.pwrite;
      req_in.err = (apb.paddr[1:0] != 2'b00) || (apb.paddr >= ADDR_LIMIT) ||
                   (apb.pwrite && (req_in.idx == IDX_W'(0) ||
                                   req_in.idx == IDX_W'(2) ||
                                   req_in.idx == IDX_W'(3)));
   end

   // With zero wait states the response is loaded on the setup edge itself,
   // before req_q holds the new transfer, so take the live decode then.
   assign req_sel = (state == IDLE) ? req_in : req_q;

   always_comb begin
      rd_mux = '0;
      case (req_sel.idx)
         IDX_W'(0): rd_mux = DATA_WIDTH'(ID_VALUE);
         IDX_W'(2): rd_mux = xfer_cnt;
         IDX_W'(3): rd_mux = err_cnt;
         default:   rd_mux = regs[req_sel.idx];
      endcase
      rd_val = (req_sel.err || req_sel.wr) ? '0 : rd_mux;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (setup) begin
               cnt_nxt   = CNT_W'(WAIT_STATES);
               state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (!apb.psel)         state_nxt = IDLE;   // abort: nothing committed
            else if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         xfer_cnt  <= '0;
         err_cnt   <= '0;
         for (int i = 0; i < 2**IDX_W; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (setup) req_q <= req_in;

         // Outputs are loaded only for the single RESP cycle, zero otherwise.
         pready_q  <= (state_nxt == RESP);
         pslverr_q <= (state_nxt == RESP) && req_sel.err;
         prdata_q  <= (state_nxt == RESP) ? rd_val : '0;

         // Closing edge of the transfer: commit and count. Counters read during
         // this transfer already returned their pre-update value.
         if (state == RESP) begin
            if (req_q.err) begin
               if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else begin
               xfer_cnt <= xfer_cnt + 1'b1;
               if (req_q.wr) regs[req_q.idx] <= apb.pwdata;
            end
         end
      end
   end

   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign apb.prdata  = prdata_q;
endmodule
